axi_write_arbiter: RTL and testbench
====================================

Name: axi_write_arbiter

Overview:
- Two-master to one-slave arbiter for the AXI write path: AW, W and B channels.
- Grants one master per write transaction, round-robin.
- Holds the grant from the AW handshake through the W burst (WLAST) to the B handshake.
- Extends the 4-bit master ID to the 8-bit slave ID so the B response routes back to the issuing master.

Parameters:
- ID_BITS, 4, master-side ID width
- IDS_BITS, 8, slave-side ID width; upper bits carry the master tag
- ADDR_BITS, 32, address width
- DATA_BITS, 32, data width
- STRB_BITS, 4, write strobe width
- LEN_BITS, 4, burst length width

Ports (Mx = M0 and M1, one copy each):
- ACLK  in  1  clock
- ARESETn  in  1  synchronous reset, active low
- Mx_AWID  in  ID_BITS  master write ID
- Mx_AWADDR  in  ADDR_BITS  write address
- Mx_AWLEN  in  LEN_BITS  burst length
- Mx_AWSIZE  in  3  beat size
- Mx_AWBURST  in  2  burst type
- Mx_AWVALID  in  1  address valid
- Mx_AWREADY  out  1  address ready
- Mx_WDATA  in  DATA_BITS  write data
- Mx_WSTRB  in  STRB_BITS  byte strobes
- Mx_WLAST  in  1  last beat
- Mx_WVALID  in  1  data valid
- Mx_WREADY  out  1  data ready
- Mx_BID  out  ID_BITS  response ID
- Mx_BRESP  out  2  response code
- Mx_BVALID  out  1  response valid
- Mx_BREADY  in  1  response ready
- S_AWID  out  IDS_BITS  {zeros, grant, Mx_AWID}
- S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID  out  as master  forwarded address channel
- S_AWREADY  in  1  slave address ready
- S_WDATA, S_WSTRB, S_WLAST, S_WVALID  out  as master  forwarded data channel
- S_WREADY  in  1  slave data ready
- S_BID  in  IDS_BITS  slave response ID
- S_BRESP  in  2  slave response code
- S_BVALID  in  1  slave response valid
- S_BREADY  out  1  slave response ready

Behaviour:
- Reset: ARESETn sampled low at a rising ACLK edge sends the FSM to IDLE and sets last_grant=1, so M0 wins the first tie.
- Outputs in IDLE / after reset: all VALID and READY outputs 0; S_* payloads 0; Mx_BID and Mx_BRESP 0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - Only M0_AWVALID high: grant=0. Only M1_AWVALID high: grant=1.
  - Both high: grant = ~last_grant.
  - Any request causes grant to be registered and the FSM to go to ADDR next cycle. No request: stay in IDLE.
  - No AWREADY is asserted in IDLE. AW handshake latency is ≥1 cycle after AWVALID rises.
- ADDR:
  - S_AW* driven combinationally from the granted master; S_AWID = {(IDS_BITS-ID_BITS-1)'b0, grant, AWID}.
  - Granted Mx_AWREADY = S_AWREADY; the other master's AWREADY = 0.
  - On S_AWVALID && S_AWREADY: go to DATA and set last_grant = grant.
- DATA:
  - S_W* forwarded from the granted master; granted Mx_WREADY = S_WREADY; the other master's WREADY = 0.
  - W beats are never forwarded outside DATA.
  - On S_WVALID && S_WREADY && S_WLAST: go to RESP.
- RESP:
  - S_BREADY = granted Mx_BREADY; granted Mx_BVALID = S_BVALID.
  - Mx_BID = S_BID[ID_BITS-1:0]; Mx_BRESP = S_BRESP.
  - The non-granted master's BVALID = 0.
  - On S_BVALID && S_BREADY: return to IDLE.
- Back-to-back: a new arbitration starts no earlier than the cycle after the RESP handshake (the IDLE cycle). No overlap between transactions.
- A request arriving mid-transaction from the other master waits, with AWREADY=0, until the next IDLE.
- Reset mid-transaction: immediate IDLE next edge; in-flight burst abandoned; no B returned.
- S_BID tag bit disagreeing with grant: response still routed to the granted master. Mismatch is a verification assertion error.

Test Plan:
- Single write: M0 AWID=3, AWADDR=0x1000, AWLEN=0, one beat WDATA=0xDEADBEEF WSTRB=0xF → S_AWID=0x03; S_WDATA matches; M0_BID=3, M0_BVALID pulse; 4-cycle minimum with all readies held high.
- Simultaneous AWVALID from M0 and M1 after reset → M0 granted first, M1 second; order repeats M0, M1, M0 across three back-to-back rounds.
- M1 burst AWLEN=3 (4 beats), S_WREADY toggling 1-0-1-0 → exactly 4 beats forwarded; FSM enters RESP only on the WLAST handshake; S_AWID=0x1N, where N is M1_AWID.
- M1 raises AWVALID during an M0 DATA phase → M1_AWREADY stays 0 until M0's B handshake completes; M1 granted in the following IDLE.
- B backpressure: M0_BREADY=0 for 5 cycles → M0_BVALID held, S_BREADY=0; handshake completes on the cycle BREADY rises.
- ARESETn low during DATA beat 2 of 4 → next cycle all VALID/READY outputs 0, FSM in IDLE; a fresh M1 request is then granted normally.

Source files
------------

// File: rtl/axi_write_arbiter.sv
// Two-master to one-slave AXI write-path arbiter (AW, W, B), round-robin per transaction.
// Latency: arbitration takes one IDLE cycle; AW/W/B are then forwarded combinationally.
// Backpressure: slave readies pass straight to the granted master; the other master sees ready=0.
module axi_write_arbiter #(
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int STRB_BITS = 4,
  parameter int LEN_BITS  = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  // master 0
  input  logic [ID_BITS-1:0]   M0_AWID,
  input  logic [ADDR_BITS-1:0] M0_AWADDR,
  input  logic [LEN_BITS-1:0]  M0_AWLEN,
  input  logic [2:0]           M0_AWSIZE,
  input  logic [1:0]           M0_AWBURST,
  input  logic                 M0_AWVALID,
  output logic                 M0_AWREADY,
  input  logic [DATA_BITS-1:0] M0_WDATA,
  input  logic [STRB_BITS-1:0] M0_WSTRB,
  input  logic                 M0_WLAST,
  input  logic                 M0_WVALID,
  output logic                 M0_WREADY,
  output logic [ID_BITS-1:0]   M0_BID,
  output logic [1:0]           M0_BRESP,
  output logic                 M0_BVALID,
  input  logic                 M0_BREADY,
  // master 1
  input  logic [ID_BITS-1:0]   M1_AWID,
  input  logic [ADDR_BITS-1:0] M1_AWADDR,
  input  logic [LEN_BITS-1:0]  M1_AWLEN,
  input  logic [2:0]           M1_AWSIZE,
  input  logic [1:0]           M1_AWBURST,
  input  logic                 M1_AWVALID,
  output logic                 M1_AWREADY,
  input  logic [DATA_BITS-1:0] M1_WDATA,
  input  logic [STRB_BITS-1:0] M1_WSTRB,
  input  logic                 M1_WLAST,
  input  logic                 M1_WVALID,
  output logic                 M1_WREADY,
  output logic [ID_BITS-1:0]   M1_BID,
  output logic [1:0]           M1_BRESP,
  output logic                 M1_BVALID,
  input  logic                 M1_BREADY,
  // slave
  output logic [IDS_BITS-1:0]  S_AWID,
  output logic [ADDR_BITS-1:0] S_AWADDR,
  output logic [LEN_BITS-1:0]  S_AWLEN,
  output logic [2:0]           S_AWSIZE,
  output logic [1:0]           S_AWBURST,
  output logic                 S_AWVALID,
  input  logic                 S_AWREADY,
  output logic [DATA_BITS-1:0] S_WDATA,
  output logic [STRB_BITS-1:0] S_WSTRB,
  output logic                 S_WLAST,
  output logic                 S_WVALID,
  input  logic                 S_WREADY,
  input  logic [IDS_BITS-1:0]  S_BID,
  input  logic [1:0]           S_BRESP,
  input  logic                 S_BVALID,
  output logic                 S_BREADY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  logic   grant;       // 0 = M0 owns the slave, 1 = M1
  logic   last_grant;  // winner of the previous AW handshake
  logic   arb_grant;
  logic   aw_hs;
  logic   w_last_hs;
  logic   b_hs;
  logic   unused_bid_hi;

  // Tag bits are only consumed by the routing check below; routing itself follows grant.
  assign unused_bid_hi = ^S_BID[IDS_BITS-1:ID_BITS];

  assign aw_hs     = S_AWVALID && S_AWREADY;
  assign w_last_hs = S_WVALID && S_WREADY && S_WLAST;
  assign b_hs      = S_BVALID && S_BREADY;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    arb_grant = M1_AWVALID;
    if (M0_AWVALID && M1_AWVALID) begin
      arb_grant = ~last_grant;
    end
  end

  // Transaction FSM: grant is held from arbitration until the B handshake completes.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (M0_AWVALID || M1_AWVALID) begin
            grant <= arb_grant;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            last_grant <= grant;
            state      <= DATA;
          end
        end
        DATA: begin
          if (w_last_hs) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel steering: only the channel of the current phase is connected, everything else idles at 0.
  always_comb begin
    S_AWID     = '0;
    S_AWADDR   = '0;
    S_AWLEN    = '0;
    S_AWSIZE   = '0;
    S_AWBURST  = '0;
    S_AWVALID  = 1'b0;
    S_WDATA    = '0;
    S_WSTRB    = '0;
    S_WLAST    = 1'b0;
    S_WVALID   = 1'b0;
    S_BREADY   = 1'b0;
    M0_AWREADY = 1'b0;
    M1_AWREADY = 1'b0;
    M0_WREADY  = 1'b0;
    M1_WREADY  = 1'b0;
    M0_BID     = '0;
    M0_BRESP   = '0;
    M0_BVALID  = 1'b0;
    M1_BID     = '0;
    M1_BRESP   = '0;
    M1_BVALID  = 1'b0;
    case (state)
      ADDR: begin
        S_AWID[ID_BITS-1:0] = grant ? M1_AWID : M0_AWID;
        S_AWID[ID_BITS]     = grant;
        S_AWADDR            = grant ? M1_AWADDR : M0_AWADDR;
        S_AWLEN             = grant ? M1_AWLEN : M0_AWLEN;
        S_AWSIZE            = grant ? M1_AWSIZE : M0_AWSIZE;
        S_AWBURST           = grant ? M1_AWBURST : M0_AWBURST;
        S_AWVALID           = grant ? M1_AWVALID : M0_AWVALID;
        M0_AWREADY          = !grant && S_AWREADY;
        M1_AWREADY          = grant && S_AWREADY;
      end
      DATA: begin
        S_WDATA   = grant ? M1_WDATA : M0_WDATA;
        S_WSTRB   = grant ? M1_WSTRB : M0_WSTRB;
        S_WLAST   = grant ? M1_WLAST : M0_WLAST;
        S_WVALID  = grant ? M1_WVALID : M0_WVALID;
        M0_WREADY = !grant && S_WREADY;
        M1_WREADY = grant && S_WREADY;
      end
      RESP: begin
        S_BREADY = grant ? M1_BREADY : M0_BREADY;
        if (grant) begin
          M1_BVALID = S_BVALID;
          M1_BID    = S_BID[ID_BITS-1:0];
          M1_BRESP  = S_BRESP;
        end else begin
          M0_BVALID = S_BVALID;
          M0_BID    = S_BID[ID_BITS-1:0];
          M0_BRESP  = S_BRESP;
        end
      end
      default: ;
    endcase
  end

  // A response whose master tag disagrees with the grant means the slave corrupted the ID.
  assert property (@(posedge ACLK) disable iff (!ARESETn)
                   (state == RESP && S_BVALID) |-> (S_BID[ID_BITS] == grant));

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: two master drivers, a responding slave and a scoreboard.
// Expected AW/W/B contents and grant order are queued when stimulus is issued.
// The monitor pops and compares on every handshake; scenario tasks add cycle-exact checks.
module tb_axi_write_arbiter;

  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  m_awid    [2];
  logic [31:0] m_awaddr  [2];
  logic [3:0]  m_awlen   [2];
  logic [2:0]  m_awsize  [2];
  logic [1:0]  m_awburst [2];
  logic        m_awvalid [2];
  logic        m_awready [2];
  logic [31:0] m_wdata   [2];
  logic [3:0]  m_wstrb   [2];
  logic        m_wlast   [2];
  logic        m_wvalid  [2];
  logic        m_wready  [2];
  logic [3:0]  m_bid     [2];
  logic [1:0]  m_bresp   [2];
  logic        m_bvalid  [2];
  logic        m_bready  [2];
  int          bready_delay [2];

  logic [7:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [3:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_awvalid;
  logic        s_awready = 1'b1;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_wvalid;
  logic        s_wready = 1'b1;
  logic [7:0]  s_bid = 8'h00;
  logic [1:0]  s_bresp = 2'b00;
  logic        s_bvalid = 1'b0;
  logic        s_bready;
  logic        wtoggle = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  logic [48:0] exp_aw0 [$];
  logic [48:0] exp_aw1 [$];
  logic [36:0] exp_w0 [$];
  logic [36:0] exp_w1 [$];
  logic [5:0]  exp_b0 [$];
  logic [5:0]  exp_b1 [$];
  logic        exp_grant [$];

  logic       cur_m = 1'b0;
  logic       hs_aw = 1'b0;
  logic       hs_wlast = 1'b0;
  logic       hs_b = 1'b0;
  logic [7:0] aw_id_samp = 8'h00;
  logic [7:0] pend_id = 8'h00;

  axi_write_arbiter dut (
    .ACLK(clk), .ARESETn(rst_n),
    .M0_AWID(m_awid[0]), .M0_AWADDR(m_awaddr[0]), .M0_AWLEN(m_awlen[0]), .M0_AWSIZE(m_awsize[0]),
    .M0_AWBURST(m_awburst[0]), .M0_AWVALID(m_awvalid[0]), .M0_AWREADY(m_awready[0]),
    .M0_WDATA(m_wdata[0]), .M0_WSTRB(m_wstrb[0]), .M0_WLAST(m_wlast[0]), .M0_WVALID(m_wvalid[0]),
    .M0_WREADY(m_wready[0]), .M0_BID(m_bid[0]), .M0_BRESP(m_bresp[0]), .M0_BVALID(m_bvalid[0]),
    .M0_BREADY(m_bready[0]),
    .M1_AWID(m_awid[1]), .M1_AWADDR(m_awaddr[1]), .M1_AWLEN(m_awlen[1]), .M1_AWSIZE(m_awsize[1]),
    .M1_AWBURST(m_awburst[1]), .M1_AWVALID(m_awvalid[1]), .M1_AWREADY(m_awready[1]),
    .M1_WDATA(m_wdata[1]), .M1_WSTRB(m_wstrb[1]), .M1_WLAST(m_wlast[1]), .M1_WVALID(m_wvalid[1]),
    .M1_WREADY(m_wready[1]), .M1_BID(m_bid[1]), .M1_BRESP(m_bresp[1]), .M1_BVALID(m_bvalid[1]),
    .M1_BREADY(m_bready[1]),
    .S_AWID(s_awid), .S_AWADDR(s_awaddr), .S_AWLEN(s_awlen), .S_AWSIZE(s_awsize),
    .S_AWBURST(s_awburst), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
    .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WLAST(s_wlast), .S_WVALID(s_wvalid),
    .S_WREADY(s_wready), .S_BID(s_bid), .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready)
  );

  // Scoreboard monitor: compares every completed handshake against the queued expectation.
  always @(negedge clk) begin : monitor
    logic [48:0] e_aw;
    logic [36:0] e_w;
    logic [5:0]  e_b;
    hs_aw    = 1'b0;
    hs_wlast = 1'b0;
    hs_b     = 1'b0;
    if (rst_n) begin
      if (s_awvalid && s_awready) begin
        hs_aw      = 1'b1;
        aw_id_samp = s_awid;
        e_aw       = 'x;
        if (exp_grant.size() > 0) begin
          cur_m = exp_grant.pop_front();
          if (!cur_m && exp_aw0.size() > 0) e_aw = exp_aw0.pop_front();
          else if (cur_m && exp_aw1.size() > 0) e_aw = exp_aw1.pop_front();
        end
        n_chk++;
        if ({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst} !== e_aw)
          $display("FAIL aw_fwd: got %h, required %h", {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst}, e_aw);
        else n_pass++;
      end
      if (s_wvalid && s_wready) begin
        hs_wlast = s_wlast;
        e_w      = 'x;
        if (!cur_m && exp_w0.size() > 0) e_w = exp_w0.pop_front();
        else if (cur_m && exp_w1.size() > 0) e_w = exp_w1.pop_front();
        n_chk++;
        if ({s_wdata, s_wstrb, s_wlast} !== e_w)
          $display("FAIL w_fwd: got %h, required %h", {s_wdata, s_wstrb, s_wlast}, e_w);
        else n_pass++;
      end
      for (int m = 0; m < 2; m++) begin
        if (m_bvalid[m] && m_bready[m]) begin
          e_b = 'x;
          if (m == 0 && exp_b0.size() > 0) e_b = exp_b0.pop_front();
          else if (m == 1 && exp_b1.size() > 0) e_b = exp_b1.pop_front();
          n_chk++;
          if ({m_bid[m], m_bresp[m]} !== e_b)
            $display("FAIL b_route m%0d: got %h, required %h", m, {m_bid[m], m_bresp[m]}, e_b);
          else n_pass++;
        end
      end
      if (m_bvalid[0] || m_bvalid[1]) begin
        n_chk++;
        if (m_bvalid[0] && m_bvalid[1]) $display("FAIL b_exclusive: got both BVALID=1, required one");
        else n_pass++;
      end
      hs_b = s_bvalid && s_bready;
    end
  end

  // Slave responder: answers each write with BID=AWID and BRESP derived from the ID.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      s_bvalid = 1'b0;
    end else begin
      if (hs_b) s_bvalid = 1'b0;
      if (hs_aw) pend_id = aw_id_samp;
      if (hs_wlast) begin
        s_bvalid = 1'b1;
        s_bid    = pend_id;
        s_bresp  = pend_id[1:0] ^ 2'b10;
      end
    end
    s_wready = wtoggle ? ~s_wready : 1'b1;
  end

  // Master driver: queues expectations, then performs AW, W burst and B as an AXI master would.
  task automatic m_write(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [31:0] dbase);
    logic [7:0]  sid;
    logic [36:0] wexp;
    int n;
    sid = {3'b000, m[0], id};
    if (m == 0) begin
      exp_aw0.push_back({sid, addr, len, 3'd2, 2'b01});
      exp_b0.push_back({id, id[1:0] ^ 2'b10});
    end else begin
      exp_aw1.push_back({sid, addr, len, 3'd2, 2'b01});
      exp_b1.push_back({id, id[1:0] ^ 2'b10});
    end
    for (int i = 0; i <= int'(len); i++) begin
      wexp = {dbase + 32'(i), 4'hF - 4'(i), (i == int'(len))};
      if (m == 0) exp_w0.push_back(wexp);
      else exp_w1.push_back(wexp);
    end
    m_awid[m] = id; m_awaddr[m] = addr; m_awlen[m] = len;
    m_awsize[m] = 3'd2; m_awburst[m] = 2'b01; m_awvalid[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_awready[m] && n < TMO);
    if (!m_awready[m]) begin
      n_chk++;
      $display("FAIL aw_timeout m%0d: AWREADY=0 after %0d cycles, required 1", m, n);
    end
    @(posedge clk); #1;
    m_awvalid[m] = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      m_wdata[m] = dbase + 32'(i); m_wstrb[m] = 4'hF - 4'(i);
      m_wlast[m] = (i == int'(len)); m_wvalid[m] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!m_wready[m] && n < TMO);
      if (!m_wready[m]) begin
        n_chk++;
        $display("FAIL w_timeout m%0d beat %0d: WREADY=0, required 1", m, i);
      end
      @(posedge clk); #1;
    end
    m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
    if (bready_delay[m] > 0) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!m_bvalid[m] && n < TMO);
      repeat (bready_delay[m]) begin @(posedge clk); #1; end
    end
    m_bready[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_bvalid[m] && n < TMO);
    if (!m_bvalid[m]) begin
      n_chk++;
      $display("FAIL b_timeout m%0d: BVALID=0 after %0d cycles, required 1", m, n);
    end
    @(posedge clk); #1;
    m_bready[m] = 1'b0;
  endtask

  task automatic test_reset;
    for (int m = 0; m < 2; m++) begin
      m_awid[m] = 4'hC; m_awaddr[m] = 32'hFFFF_0000; m_awlen[m] = 4'h7; m_awsize[m] = 3'd2;
      m_awburst[m] = 2'b01; m_awvalid[m] = 1'b0; m_wdata[m] = 32'h1234_5678; m_wstrb[m] = 4'hF;
      m_wlast[m] = 1'b1; m_wvalid[m] = 1'b0; m_bready[m] = 1'b1; bready_delay[m] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({s_awvalid, s_wvalid, s_bready, m_awready[0], m_awready[1], m_wready[0], m_wready[1],
         m_bvalid[0], m_bvalid[1]} !== 9'b0)
      $display("FAIL reset_handshake_outs: got %b, required 0", {s_awvalid, s_wvalid, s_bready,
               m_awready[0], m_awready[1], m_wready[0], m_wready[1], m_bvalid[0], m_bvalid[1]});
    else n_pass++;
    n_chk++;
    if ({s_awid, s_awaddr, s_awlen, s_wdata, s_wstrb, s_wlast, m_bid[0], m_bresp[0], m_bid[1], m_bresp[1]} !== '0)
      $display("FAIL reset_payloads: got %h, required 0", {s_awid, s_awaddr, s_awlen, s_wdata, s_wstrb,
               s_wlast, m_bid[0], m_bresp[0], m_bid[1], m_bresp[1]});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({s_awvalid, s_awid, s_awaddr, s_wvalid, s_wdata, s_bready, m_awready[0], m_awready[1]} !== '0)
      $display("FAIL idle_outputs: got %h, required 0", {s_awvalid, s_awid, s_awaddr, s_wvalid, s_wdata,
               s_bready, m_awready[0], m_awready[1]});
    else n_pass++;
    @(posedge clk); #1;
    m_bready[0] = 1'b0; m_bready[1] = 1'b0;
  endtask

  task automatic test_round_robin;
    for (int r = 0; r < 3; r++) begin
      exp_grant.push_back(1'b0);
      exp_grant.push_back(1'b1);
    end
    fork
      begin
        for (int k = 0; k < 3; k++) m_write(0, 4'(k + 1), 32'h100 + 32'(k * 16), 4'(k), 32'h0A00_0000 + 32'(k * 256));
      end
      begin
        for (int k = 0; k < 3; k++) m_write(1, 4'(k + 8), 32'h200 + 32'(k * 16), 4'(k), 32'h0B00_0000 + 32'(k * 256));
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_single_write;
    exp_grant.push_back(1'b0);
    fork
      m_write(0, 4'd3, 32'h0000_1000, 4'd0, 32'hDEAD_BEEF);
      begin
        @(negedge clk);
        n_chk++;
        if ({m_awready[0], s_awvalid} !== 2'b00)
          $display("FAIL single_idle: got AWREADY,S_AWVALID=%b, required 00", {m_awready[0], s_awvalid});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({m_awready[0], s_awvalid, s_awid, s_awaddr} !== {1'b1, 1'b1, 8'h03, 32'h0000_1000})
          $display("FAIL single_addr: got %h, required %h", {m_awready[0], s_awvalid, s_awid, s_awaddr},
                   {1'b1, 1'b1, 8'h03, 32'h0000_1000});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({m_wready[0], s_wvalid, s_wlast, s_wdata, s_wstrb} !== {3'b111, 32'hDEAD_BEEF, 4'hF})
          $display("FAIL single_data: got %h, required %h", {m_wready[0], s_wvalid, s_wlast, s_wdata, s_wstrb},
                   {3'b111, 32'hDEAD_BEEF, 4'hF});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({m_bvalid[0], m_bid[0], m_bresp[0], m_bvalid[1]} !== {1'b1, 4'd3, 2'b01, 1'b0})
          $display("FAIL single_resp: got %h, required %h", {m_bvalid[0], m_bid[0], m_bresp[0], m_bvalid[1]},
                   {1'b1, 4'd3, 2'b01, 1'b0});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({m_bvalid[0], s_awvalid, s_wvalid, s_bready} !== 4'b0000)
          $display("FAIL single_done: got %b, required 0000", {m_bvalid[0], s_awvalid, s_wvalid, s_bready});
        else n_pass++;
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_burst_wready_toggle;
    int beats;
    int bad;
    int n;
    beats = 0; bad = 0; n = 0;
    wtoggle = 1'b1;
    exp_grant.push_back(1'b1);
    fork
      m_write(1, 4'hA, 32'h0000_4000, 4'd3, 32'hA000_0000);
      begin
        do begin @(negedge clk); n++; end while (!s_wvalid && n < TMO);
        while (beats < 4 && n < TMO) begin
          if (!s_wvalid || m_wready[1] !== s_wready || m_wready[0] !== 1'b0) bad++;
          if (s_wvalid && s_wready) begin
            beats++;
            if (s_wlast !== (beats == 4)) bad++;
          end
          if (beats < 4) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        n_chk++;
        if ({s_wvalid, m_wready[1], m_bvalid[1], s_bready} !== 4'b0011)
          $display("FAIL burst_resp_entry: got %b, required 0011", {s_wvalid, m_wready[1], m_bvalid[1], s_bready});
        else n_pass++;
      end
    join
    wtoggle = 1'b0;
    n_chk++;
    if (beats !== 4) $display("FAIL burst_beats: got %0d, required 4", beats);
    else n_pass++;
    n_chk++;
    if (bad !== 0) $display("FAIL burst_data_phase: got %0d bad cycles, required 0", bad);
    else n_pass++;
    n_chk++;
    if (exp_w1.size() !== 0) $display("FAIL burst_leftover: got %0d beats pending, required 0", exp_w1.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_request;
    int bad;
    bad = 0;
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    fork
      m_write(0, 4'h6, 32'h0000_5000, 4'd1, 32'h5000_0000);
      begin
        repeat (2) begin @(posedge clk); #1; end
        m_write(1, 4'h7, 32'h0000_6000, 4'd0, 32'h6000_0000);
      end
      begin
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (m_awready[1] !== 1'b0) bad++;
        end
        @(negedge clk);
        n_chk++;
        if ({m_awready[1], m_awready[0], s_awid} !== {1'b1, 1'b0, 8'h17})
          $display("FAIL mid_grant: got %h, required %h", {m_awready[1], m_awready[0], s_awid}, {1'b1, 1'b0, 8'h17});
        else n_pass++;
      end
    join
    n_chk++;
    if (bad !== 0) $display("FAIL mid_awready_held: got %0d cycles AWREADY=1, required 0", bad);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_b_backpressure;
    int n;
    int bad;
    n = 0; bad = 0;
    bready_delay[0] = 5;
    exp_grant.push_back(1'b0);
    fork
      m_write(0, 4'h2, 32'h0000_7000, 4'd0, 32'h7777_0000);
      begin
        do begin @(negedge clk); n++; end while (!m_bvalid[0] && n < TMO);
        for (int c = 0; c < 5; c++) begin
          if (m_bvalid[0] !== 1'b1 || s_bready !== 1'b0) bad++;
          @(negedge clk);
        end
        n_chk++;
        if ({m_bvalid[0], s_bready} !== 2'b11)
          $display("FAIL bp_release: got BVALID,S_BREADY=%b, required 11", {m_bvalid[0], s_bready});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({m_bvalid[0], s_bready} !== 2'b00)
          $display("FAIL bp_after: got BVALID,S_BREADY=%b, required 00", {m_bvalid[0], s_bready});
        else n_pass++;
      end
    join
    bready_delay[0] = 0;
    n_chk++;
    if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles, required 0", bad);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst;
    int n;
    n = 0;
    exp_grant.push_back(1'b0);
    exp_aw0.push_back({8'h05, 32'h0000_2000, 4'd3, 3'd2, 2'b01});
    exp_w0.push_back({32'hC000_0000, 4'hF, 1'b0});
    m_awid[0] = 4'h5; m_awaddr[0] = 32'h0000_2000; m_awlen[0] = 4'd3;
    m_awsize[0] = 3'd2; m_awburst[0] = 2'b01; m_awvalid[0] = 1'b1;
    do begin @(negedge clk); n++; end while (!m_awready[0] && n < TMO);
    @(posedge clk); #1;
    m_awvalid[0] = 1'b0;
    m_wdata[0] = 32'hC000_0000; m_wstrb[0] = 4'hF; m_wlast[0] = 1'b0; m_wvalid[0] = 1'b1;
    @(posedge clk); #1;
    m_wdata[0] = 32'hC000_0001; m_wstrb[0] = 4'hE;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_wvalid[0] = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({s_awvalid, s_wvalid, s_bready, m_awready[0], m_awready[1], m_wready[0], m_wready[1],
         m_bvalid[0], m_bvalid[1], s_wdata} !== '0)
      $display("FAIL reset_mid_outputs: got %h, required 0", {s_awvalid, s_wvalid, s_bready, m_awready[0],
               m_awready[1], m_wready[0], m_wready[1], m_bvalid[0], m_bvalid[1], s_wdata});
    else n_pass++;
    n_chk++;
    if (exp_w0.size() !== 0) $display("FAIL reset_mid_beats: got %0d beats pending, required 0", exp_w0.size());
    else n_pass++;
    @(posedge clk); #1;
    exp_grant.push_back(1'b1);
    m_write(1, 4'h9, 32'h0000_3000, 4'd0, 32'h9999_0000);
    @(posedge clk); #1;
  endtask

  task automatic test_drain;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (exp_grant.size() + exp_aw0.size() + exp_aw1.size() + exp_w0.size() + exp_w1.size() +
        exp_b0.size() + exp_b1.size() !== 0)
      $display("FAIL drain: got %0d expectations left, required 0", exp_grant.size() + exp_aw0.size() +
               exp_aw1.size() + exp_w0.size() + exp_w1.size() + exp_b0.size() + exp_b1.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_burst_wready_toggle();
    test_mid_request();
    test_b_backpressure();
    test_reset_mid_burst();
    test_drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
    $fatal(1);
  end

endmodule
